// File: rtl/uart_tx.sv
// Byte-wide UART transmitter: a small FIFO feeding an 8N1 serialiser, with
// an optional even-parity bit. tx_o is registered from the next-state decode
// so the line never glitches.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o,
    output logic       busy_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);

    // Parameter combinations the counters and pointer wrap cannot support.
    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("uart_tx: CLKS_PER_BIT must be at least 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
            $error("uart_tx: FIFO_DEPTH must be a power of two and at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [7:0]       head;

    // ready_o depends only on the registered count, so a same-cycle pop
    // never opens a slot for a byte offered while full.
    assign ready_o    = (count_q != FULL_COUNT);
    assign fifo_empty = (count_q == '0);
    assign push       = valid_i && ready_o && !rst_i;
    assign head       = mem[rd_ptr_q];

    // Byte storage, written at the tail.
    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are live, and resetting memory would block RAM inference.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             tx_q, tx_d;
    logic             bit_last;

    assign bit_last = (cnt_q == BIT_LAST);
    assign tx_o     = tx_q;
    assign busy_o   = (state_q != IDLE) || !fifo_empty;

    // State, bit timer, shift register and the registered line output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state, FIFO pop and next line level.
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = bit_last ? '0 : cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        tx_d    = 1'b1;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_last) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_last) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_last) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // Chain straight into the next start bit when more data waits.
                if (bit_last) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            shift_d = head;
            par_d   = ^head;
            cnt_d   = '0;
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (no parity / even parity) with
// CLKS_PER_BIT=4 and FIFO_DEPTH=4. A frame-timeline model predicts tx_o,
// busy_o and ready_o every cycle; directed tests pin exact cycle positions,
// and a serial receiver decodes the line back into characters.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] valid_w = '0;
    logic [7:0] data_w [2] = '{8'h00, 8'h00};
    wire  [1:0] ready_w;
    wire  [1:0] tx_w;
    wire  [1:0] busy_w;

    int    n_cmp   = 0;
    int    n_bad   = 0;
    bit    cmp_en  = 1'b0;
    bit    mon_chk = 1'b0;
    string line_buf  [2];
    string last_line [2];
    logic [7:0] rx_last [2] = '{8'h00, 8'h00};

    logic cap_tx   [64];
    logic cap_busy [64];

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .FIFO_DEPTH(DEPTH)) dut0 (
        .clk_i  (clk),
        .rst_i  (rst),
        .data_i (data_w[0]),
        .valid_i(valid_w[0]),
        .ready_o(ready_w[0]),
        .tx_o   (tx_w[0]),
        .busy_o (busy_w[0])
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk_i  (clk),
        .rst_i  (rst),
        .data_i (data_w[1]),
        .valid_i(valid_w[1]),
        .ready_o(ready_w[1]),
        .tx_o   (tx_w[1]),
        .busy_o (busy_w[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Samples lane g for n cycles starting in the current cycle; a valid
    // raised for cycle 0 is dropped after that cycle's edge.
    task automatic capture(input int g, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            cap_tx[c]   = tx_w[g];
            cap_busy[c] = busy_w[g];
            next_cycle();
            valid_w[g] = 1'b0;
        end
    endtask

    task automatic wait_idle(input int limit);
        int c;
        c = 0;
        while (busy_w != 2'b00 && c < limit) begin
            next_cycle();
            c++;
        end
        check("idle_timeout", busy_w, 0);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int NBITS = 10 + g;

        logic [7:0]  q [$];
        bit          act;
        int          pos;
        logic [10:0] fb;

        // Line levels of one frame, index 0 first on the wire.
        function automatic logic [10:0] frame_of(input logic [7:0] b);
            logic [10:0] f;
            f      = '1;
            f[0]   = 1'b0;
            f[8:1] = b;
            if (NBITS == 11) f[9] = ^b;
            return f;
        endfunction

        // Timeline model: a frame occupies NBITS*CPB cycles starting the
        // cycle after its byte leaves the queue; the queue is served
        // whenever no frame is running or one ends at this edge.
        initial begin
            int sz;
            bit do_push;
            act = 1'b0;
            pos = 0;
            fb  = '1;
            forever begin
                @(posedge clk);
                if (rst) begin
                    q.delete();
                    act = 1'b0;
                    pos = 0;
                end else begin
                    sz      = q.size();
                    do_push = valid_w[g] && (sz < DEPTH);
                    if (act) pos++;
                    if (act && pos == NBITS * CPB) act = 1'b0;
                    if (!act && sz != 0) begin
                        fb  = frame_of(q.pop_front());
                        act = 1'b1;
                        pos = 0;
                    end
                    if (do_push) q.push_back(data_w[g]);
                end
            end
        end

        // Per-cycle comparison against the model.
        initial forever begin
            @(negedge clk);
            if (cmp_en) begin
                check($sformatf("tx%0d", g), tx_w[g], act ? fb[pos / CPB] : 1'b1);
                check($sformatf("busy%0d", g), busy_w[g], act || q.size() != 0);
                check($sformatf("ready%0d", g), ready_w[g], q.size() < DEPTH);
            end
        end

        // Serial receiver: samples mid-bit, assembles text lines.
        initial begin
            logic [10:0] bits;
            bit          aborted;
            bit          par_err;
            logic [7:0]  b;
            forever begin
                @(negedge clk);
                if (!rst && tx_w[g] === 1'b0) begin
                    bits    = '1;
                    aborted = 1'b0;
                    for (int o = 1; o <= (NBITS - 1) * CPB + CPB / 2; o++) begin
                        @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (o % CPB == CPB / 2) bits[o / CPB] = tx_w[g];
                    end
                    if (!aborted && mon_chk) begin
                        b       = bits[8:1];
                        par_err = (NBITS == 11) && (^bits[9:1]);
                        check($sformatf("rx_start%0d", g), bits[0], 0);
                        check($sformatf("rx_stop%0d", g), bits[NBITS-1], 1);
                        check($sformatf("rx_parity%0d", g), par_err, 0);
                        rx_last[g] = b;
                        if (b == 8'h0A) begin
                            $display("[UART]: %s", line_buf[g]);
                            last_line[g] = line_buf[g];
                            line_buf[g]  = "";
                        end else begin
                            line_buf[g] = $sformatf("%s%c", line_buf[g], b);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] exp_bits;
        int         idx;
        int         c;
        int         acc [6];
        logic       r;

        line_buf[0] = "";
        line_buf[1] = "";

        // Reset and post-reset state
        rst = 1'b1;
        next_cycle();
        cmp_en = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx", tx_w[0], 1);
        check("rst_ready", ready_w[0], 1);
        check("rst_busy", busy_w[0], 0);
        check("rst_tx1", tx_w[1], 1);
        next_cycle();
        next_cycle();

        // 0x55, no parity: start low at cycle 2, each bit 4 cycles, idle at 42
        data_w[0] = 8'h55;
        valid_w[0] = 1'b1;
        capture(0, 46);
        exp_bits = 10'b1010101010;
        check("t1_tx_c1", cap_tx[1], 1);
        check("t1_busy_c1", cap_busy[1], 1);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("t1_bit%0d_first", k), cap_tx[2 + 4*k], exp_bits[k]);
            check($sformatf("t1_bit%0d_last", k), cap_tx[5 + 4*k], exp_bits[k]);
        end
        check("t1_busy_c41", cap_busy[41], 1);
        check("t1_busy_c42", cap_busy[42], 0);

        // Even parity: 0x07 -> parity 1, 44-cycle frame; 0x03 -> parity 0
        data_w[1] = 8'h07;
        valid_w[1] = 1'b1;
        capture(1, 48);
        check("t2_start", cap_tx[2], 0);
        check("t2_d2", cap_tx[14], 1);
        check("t2_d3", cap_tx[18], 0);
        check("t2_par", cap_tx[38], 1);
        check("t2_par_end", cap_tx[41], 1);
        check("t2_stop", cap_tx[42], 1);
        check("t2_busy_c45", cap_busy[45], 1);
        check("t2_busy_c46", cap_busy[46], 0);
        data_w[1] = 8'h03;
        valid_w[1] = 1'b1;
        capture(1, 48);
        check("t2b_par", cap_tx[38], 0);
        check("t2b_stop", cap_tx[45], 1);
        check("t2b_busy_c46", cap_busy[46], 0);

        // Hold valid with A1..A6: fills, stalls while full, refills after A2 pop
        for (int k = 0; k < 6; k++) acc[k] = -1;
        idx = 0;
        c = 0;
        while (idx < 6 && c < 100) begin
            data_w[0] = 8'(8'hA1 + idx);
            valid_w[0] = 1'b1;
            @(negedge clk);
            r = ready_w[0];
            if (c == 4) check("t3_ready_c4", r, 1);
            if (c == 5) check("t3_ready_c5", r, 0);
            if (c == 41) check("t3_ready_c41", r, 0);
            next_cycle();
            if (r) begin
                acc[idx] = c;
                idx++;
            end
            c++;
        end
        valid_w[0] = 1'b0;
        for (int k = 0; k < 5; k++) check($sformatf("t3_accept%0d", k), acc[k], k);
        check("t3_accept5", acc[5], 42);
        wait_idle(400);

        // Reset during data bit 3 of 0x48 with 0x11 queued and a push offered
        data_w[0] = 8'h48;
        valid_w[0] = 1'b1;
        next_cycle();
        data_w[0] = 8'h11;
        next_cycle();
        valid_w[0] = 1'b0;
        repeat (17) next_cycle();
        rst = 1'b1;
        valid_w[0] = 1'b1;
        data_w[0] = 8'h99;
        @(negedge clk);
        check("t4_bit3", tx_w[0], 1);
        next_cycle();
        rst = 1'b0;
        valid_w[0] = 1'b0;
        @(negedge clk);
        check("t4_tx", tx_w[0], 1);
        check("t4_busy", busy_w[0], 0);
        check("t4_ready", ready_w[0], 1);
        repeat (10) next_cycle();
        check("t4_still_idle", busy_w[0], 0);
        mon_chk = 1'b1;
        data_w[0] = 8'h5A;
        valid_w[0] = 1'b1;
        next_cycle();
        valid_w[0] = 1'b0;
        wait_idle(100);
        check("t4_rx_byte", rx_last[0], 8'h5A);

        // Loopback text in both parity modes
        line_buf[0] = "";
        line_buf[1] = "";
        last_line[0] = "";
        last_line[1] = "";
        for (int k = 0; k < 3; k++) begin
            data_w[0] = (k == 0) ? 8'h48 : (k == 1) ? 8'h69 : 8'h0A;
            data_w[1] = data_w[0];
            valid_w = 2'b11;
            next_cycle();
        end
        valid_w = 2'b00;
        wait_idle(300);
        repeat (4) next_cycle();
        check("t5_line0", last_line[0] == "Hi", 1);
        check("t5_line1", last_line[1] == "Hi", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
